// File: rtl/div_unit.sv
// rtl/div_unit.sv - sequential signed restoring divider for the Hi/Lo datapath
//
// Purpose: signed DATA_WIDTH/DATA_WIDTH division, one quotient bit per clock.
//   Quotient goes to Lo and remainder to Hi, with MIPS div semantics:
//   the quotient truncates toward zero and the remainder takes the sign of
//   the dividend. A zero divisor raises DivZero and leaves Hi/Lo untouched.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-low reset
//   InA        in   dividend (two's complement)
//   InB        in   divisor (two's complement)
//   DivControl in   start pulse; restarts the operation if seen while busy
//   Hi         out  remainder
//   Lo         out  quotient
//   DivExit    out  one-cycle completion pulse
//   DivZero    out  one-cycle divide-by-zero pulse (with DivExit)
//
// Build option: DIV_EARLY_EXIT_EN - when defined, an operation with
//   |InA| < |InB| skips the iterations and completes one cycle after start.

module div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] InA,
  input  logic [DATA_WIDTH-1:0] InB,
  input  logic                  DivControl,
  output logic [DATA_WIDTH-1:0] Hi,
  output logic [DATA_WIDTH-1:0] Lo,
  output logic                  DivExit,
  output logic                  DivZero
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX
  } state_t;

  state_t state;
  state_t stateNext;

  logic [CW-1:0]         counter;
  logic                  signA;
  logic                  signB;
  logic [DATA_WIDTH-1:0] magB;
  logic [DATA_WIDTH-1:0] quo;
  logic [DATA_WIDTH:0]   rem;

  logic [DATA_WIDTH-1:0] absA;
  logic [DATA_WIDTH-1:0] absB;
  logic                  divByZero;
  logic                  early;
  logic [DATA_WIDTH:0]   remShift;
  logic [DATA_WIDTH:0]   remDiff;
  logic                  fits;

  // Magnitudes are unsigned, so the most negative value maps onto itself
  // and is correctly read as 2^(DATA_WIDTH-1).
  assign absA      = InA[DATA_WIDTH-1] ? (~InA + 1'b1) : InA;
  assign absB      = InB[DATA_WIDTH-1] ? (~InB + 1'b1) : InB;
  assign divByZero = (InB == '0);

`ifdef DIV_EARLY_EXIT_EN
  assign early = (absA < absB);
`else
  assign early = 1'b0;
`endif

  // The partial remainder is always below |B|, so shifting in one quotient
  // bit needs at most DATA_WIDTH+1 bits and the subtraction never wraps.
  assign remShift = {rem[DATA_WIDTH-1:0], quo[DATA_WIDTH-1]};
  assign remDiff  = remShift - {1'b0, magB};
  assign fits     = (remShift >= {1'b0, magB});

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: stateNext = IDLE;
      ITER: if (counter == LAST_STEP) stateNext = FIX;
      FIX:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    // A start pulse wins in every state: busy means restart.
    if (DivControl) begin
      if (divByZero) begin
        stateNext = IDLE;
      end else if (early) begin
        stateNext = FIX;
      end else begin
        stateNext = ITER;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state   <= IDLE;
      counter <= '0;
      signA   <= 1'b0;
      signB   <= 1'b0;
      magB    <= '0;
      quo     <= '0;
      rem     <= '0;
      Hi      <= '0;
      Lo      <= '0;
      DivExit <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      state   <= stateNext;
      DivExit <= 1'b0;
      DivZero <= 1'b0;
      if (DivControl) begin
        if (divByZero) begin
          DivZero <= 1'b1;
          DivExit <= 1'b1;
        end else begin
          signA   <= InA[DATA_WIDTH-1];
          signB   <= InB[DATA_WIDTH-1];
          magB    <= absB;
          counter <= '0;
          if (early) begin
            // Quotient is zero and the whole dividend is the remainder.
            quo <= '0;
            rem <= {1'b0, absA};
          end else begin
            quo <= absA;
            rem <= '0;
          end
        end
      end else begin
        case (state)
          ITER: begin
            rem     <= fits ? remDiff : remShift;
            quo     <= {quo[DATA_WIDTH-2:0], fits};
            counter <= counter + CW'(1);
          end
          FIX: begin
            Lo      <= (signA ^ signB) ? (~quo + 1'b1) : quo;
            Hi      <= signA ? (~rem[DATA_WIDTH-1:0] + 1'b1) : rem[DATA_WIDTH-1:0];
            DivExit <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard testbench for div_unit

module tb_div_unit;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
    int          cyc;
  } exp_t;

`ifdef DIV_EARLY_EXIT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] InA;
  logic [31:0] InB;
  logic        DivControl;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        DivExit;
  logic        DivZero;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          probeCnt = 0;
  int          probeSeen = 0;
  logic [31:0] probeLo;
  logic [31:0] probeHi;
  logic        done = 1'b0;

  div_unit #(.DATA_WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .InA        (InA),
    .InB        (InB),
    .DivControl (DivControl),
    .Hi         (Hi),
    .Lo         (Lo),
    .DivExit    (DivExit),
    .DivZero    (DivZero)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: all comparisons happen here, away from the active edge.
  always @(negedge clock) begin
    exp_t e;
    if (probeCnt != probeSeen) begin
      probeSeen = probeCnt;
      chk("probe Lo", Lo, probeLo);
      chk("probe Hi", Hi, probeHi);
      chk("probe DivExit", {31'b0, DivExit}, 32'd0);
      chk("probe DivZero", {31'b0, DivZero}, 32'd0);
    end
    if (DivExit === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected DivExit", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("exit cycle", cyc, e.cyc);
        chk("Lo", Lo, e.lo);
        chk("Hi", Hi, e.hi);
        chk("DivZero", {31'b0, DivZero}, {31'b0, e.zero});
      end
    end else begin
      if (DivZero !== 1'b0) chk("DivZero without DivExit", {31'b0, DivZero}, 32'd0);
      if (sb.size() > 0 && cyc > sb[0].cyc) begin
        e = sb.pop_front();
        chk("DivExit timeout", cyc, e.cyc);
      end
    end
    if (done) begin
      chk("scoreboard drained", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic startOp(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lo, input logic [31:0] hi,
                         input logic zero, input int lat);
    @(negedge clock);
    InA        = a;
    InB        = b;
    DivControl = 1'b1;
    sb.push_back('{lo: lo, hi: hi, zero: zero, cyc: cyc + 1 + lat});
    @(negedge clock);
    DivControl = 1'b0;
  endtask

  task automatic runOp(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] lo, input logic [31:0] hi,
                       input logic zero, input int lat);
    startOp(a, b, lo, hi, zero, lat);
    repeat (lat + 3) @(negedge clock);
  endtask

  task automatic resetProbe();
    @(negedge clock);
    reset = 1'b0;
    sb.delete();
    @(posedge clock);
    #1;
    probeLo = 32'd0;
    probeHi = 32'd0;
    probeCnt++;
    @(negedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset      = 1'b0;
    DivControl = 1'b0;
    InA        = 32'd0;
    InB        = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    probeLo = 32'd0;
    probeHi = 32'd0;
    probeCnt++;
    @(negedge clock);
    #1;
    reset = 1'b1;

    runOp(32'd100,        32'd7,        32'h0000000E, 32'h00000002, 1'b0, 33);
    runOp(32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33);
    runOp(32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0, 33);
    runOp(32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 33);
    runOp(32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 33);
    runOp(32'hFFFFFF9C,   32'hFFFFFFF9, 32'h0000000E, 32'hFFFFFFFE, 1'b0, 33);
    runOp(32'h7FFFFFFF,   32'd1,        32'h7FFFFFFF, 32'h00000000, 1'b0, 33);
    runOp(32'h80000000,   32'd2,        32'hC0000000, 32'h00000000, 1'b0, 33);

    // Divide by zero must leave the preloaded Hi/Lo untouched.
    runOp(32'd9,          32'd4,        32'h00000002, 32'h00000001, 1'b0, 33);
    runOp(32'd5,          32'd0,        32'h00000002, 32'h00000001, 1'b1, 0);

    // Reset in the middle of an operation: no exit, outputs cleared.
    startOp(32'd100, 32'd7, 32'h0000000E, 32'h00000002, 1'b0, 33);
    repeat (9) @(negedge clock);
    resetProbe();
    runOp(32'd50,         32'd5,        32'h0000000A, 32'h00000000, 1'b0, 33);

    // Restart while busy: only the second operation completes.
    startOp(32'd100, 32'd7, 32'h0000000E, 32'h00000002, 1'b0, 33);
    repeat (4) @(negedge clock);
    void'(sb.pop_back());
    runOp(32'd20,         32'd3,        32'h00000006, 32'h00000002, 1'b0, 33);

    // |A| < |B|: early exit when enabled, full latency otherwise.
    runOp(32'd3,          32'd10,       32'h00000000, 32'h00000003, 1'b0, EARLY_LAT);
    runOp(32'hFFFFFFFD,   32'd10,       32'h00000000, 32'hFFFFFFFD, 1'b0, EARLY_LAT);

    repeat (3) @(negedge clock);
    done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Sequential signed 32/32 integer divider; the inverse of the Booth multiplier in the Hi/Lo datapath.
- The control unit pulses DivControl. The block runs a one-bit-per-cycle restoring division and writes the quotient to Lo and the remainder to Hi.
- DivExit marks completion. DivZero flags a divide-by-zero exception for the exception logic.

Parameters:
- DATA_WIDTH, 32, operand/result width; the iteration count equals DATA_WIDTH.

Ports:
- clock  input  1  system clock; all state changes on the rising edge
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clock
- InA  input  DATA_WIDTH  dividend (two's complement)
- InB  input  DATA_WIDTH  divisor (two's complement)
- DivControl  input  1  start pulse; sampled on the rising edge
- Hi  output reg  DATA_WIDTH  remainder
- Lo  output reg  DATA_WIDTH  quotient
- DivExit  output reg  1  one-cycle done pulse
- DivZero  output reg  1  one-cycle divide-by-zero pulse

Behaviour:
- Reset (reset==0 at an edge):
  - Hi=0, Lo=0, DivExit=0, DivZero=0; state=IDLE, counter=0, internal registers=0.
  - Reset overrides DivControl.
  - Reset mid-operation aborts the division; no DivExit is produced.
- States: IDLE, ITER, FIX.
- IDLE, DivControl==1, InB!=0:
  - Latch sign flags sA=InA[31] and sB=InB[31].
  - Latch magnitudes |InA| and |InB|; |0x80000000| is held as the unsigned value 0x80000000.
  - Clear the remainder register (DATA_WIDTH+1 bits) and the counter; go to ITER.
- IDLE, DivControl==1, InB==0:
  - DivZero=1 and DivExit=1 for exactly one cycle; Hi and Lo keep their previous values.
  - State stays IDLE.
- ITER, one step per edge:
  - R = {R, Q[MSB]}; Q <<= 1.
  - If R >= |B| then R -= |B| and Q[0]=1.
  - Counter increments; after the 32nd step go to FIX.
- FIX, one edge:
  - Lo = (sA^sB) ? -Q : Q.
  - Hi = sA ? -R : R.
  - DivExit=1; go to IDLE.
- Latency: the start edge is k. Steps run on edges k+1..k+32, FIX on k+33. DivExit is high between edges k+33 and k+34, for exactly one cycle.
- DivExit and DivZero are cleared on every edge where they are not being set.
- Semantics follow MIPS div:
  - the quotient truncates toward zero;
  - the remainder takes the sign of the dividend;
  - 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0 (wraps, no flag).
- Hi and Lo change only in FIX; they hold their values between operations.
- DivControl asserted while in ITER or FIX restarts the operation with the new operands; the old result is discarded.
- DivControl held high for several cycles in IDLE starts the operation once. While busy, it behaves as a restart on each asserted edge.

Optional Feature:
- Macro DIV_EARLY_EXIT_EN.
- Defined: at the start edge with InB!=0, if |InA| < |InB| (this includes InA==0):
  - Skip ITER and go directly to FIX with Q=0 and R=|InA|.
  - Result: Lo=0, Hi=InA, DivExit one cycle after the start edge (k+1).
  - All other cases are unchanged.
- Not defined: every non-zero-divisor operation takes the full 33-cycle latency.

Test Plan:
- InA=100, InB=7, pulse DivControl -> Lo=0x0000000E, Hi=0x00000002; DivExit high exactly one cycle, 33 edges after the start edge.
- InA=-7 (0xFFFFFFF9), InB=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. InA=7, InB=-2 -> Lo=0xFFFFFFFD, Hi=0x00000001.
- InA=0x80000000, InB=0xFFFFFFFF -> Lo=0x80000000, Hi=0x00000000, DivZero=0.
- Preload Hi/Lo via 9/4 (Lo=2, Hi=1), then InA=5, InB=0 -> DivZero=DivExit=1 for one cycle after the start edge; Lo=2 and Hi=1 unchanged.
- Start 100/7, drive reset=0 at iteration 10 -> Hi=Lo=0, no DivExit. Then start 50/5 -> Lo=10, Hi=0 after 33 cycles.
- Start 100/7, re-pulse DivControl at iteration 5 with 20/3 -> a single DivExit 33 cycles after the second pulse, Lo=6, Hi=2.
- With DIV_EARLY_EXIT_EN defined: 3/10 -> Lo=0, Hi=3, DivExit at k+1.
